// File: rtl/parity_window_counter_pkg.sv
// Shared types and default widths for the parity window counter and its helpers.
`timescale 1ns/1ps
package parity_window_counter_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_WIN_W  = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } pwc_state_e;

endpackage

// File: rtl/parity_window_counter_if.sv
// Sample/control/result bundle between the upstream shifter stage and the parity window counter.
`timescale 1ns/1ps
interface parity_window_counter_if
  import parity_window_counter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              start;
  logic [WIN_W-1:0]  win_len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  odd_cnt;
  logic [CNT_W-1:0]  even_cnt;
  logic              acc_parity;
  logic              last_parity;

  modport master (
    output data_in, in_valid, start, win_len,
    input  busy, done, odd_cnt, even_cnt, acc_parity, last_parity
  );

  modport slave (
    input  data_in, in_valid, start, win_len,
    output busy, done, odd_cnt, even_cnt, acc_parity, last_parity
  );
endinterface

// File: rtl/parity_window_counter_parity_reduce.sv
// Combinational XOR reduction of a data word; 1 means odd parity.
`timescale 1ns/1ps
module parity_reduce
  import parity_window_counter_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic [W-1:0] data_i,
  output logic         parity_o
);
  assign parity_o = ^data_i;
endmodule

// File: rtl/parity_window_counter.sv
// Counts odd/even parity samples over a programmable window and pulses done when it closes.
//   state    | meaning
//   ST_IDLE  | waiting for start; results frozen from the last window
//   ST_COUNT | accepting valid samples until remaining reaches zero
//   ST_DONE  | single-cycle done pulse, then back to idle
`timescale 1ns/1ps
module parity_window_counter
  import parity_window_counter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                     clk,
  input logic                     rst_n,
  parity_window_counter_if.slave  bus
);

  pwc_state_e        state_q, state_d;
  logic [WIN_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  odd_q, odd_d;
  logic [CNT_W-1:0]  even_q, even_d;
  logic              acc_q, acc_d;
  logic              last_q, last_d;
  logic              parity;

  parity_reduce #(.W(DATA_W)) u_parity (
    .data_i   (bus.data_in),
    .parity_o (parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      odd_q       <= '0;
      even_q      <= '0;
      acc_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      odd_q       <= odd_d;
      even_q      <= even_d;
      acc_q       <= acc_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    odd_d       = odd_q;
    even_d      = even_q;
    acc_d       = acc_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          odd_d  = '0;
          even_d = '0;
          acc_d  = 1'b0;
          last_d = 1'b0;
          // A zero-length window still produces a done pulse so the consumer never stalls.
          if (bus.win_len == '0) begin
            state_d = ST_DONE;
          end else begin
            remaining_d = bus.win_len;
            state_d     = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (bus.in_valid) begin
          if (parity) odd_d  = odd_q + CNT_W'(1);
          else        even_d = even_q + CNT_W'(1);
          acc_d       = acc_q ^ parity;
          last_d      = parity;
          remaining_d = remaining_q - WIN_W'(1);
          if (remaining_q == WIN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy        = (state_q == ST_COUNT);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.odd_cnt     = odd_q;
  assign bus.even_cnt    = even_q;
  assign bus.acc_parity  = acc_q;
  assign bus.last_parity = last_q;

endmodule

// File: tb/tb_parity_window_counter.sv
// Directed-vector bench for parity_window_counter with hand-computed expectations.
`timescale 1ns/1ps
module tb_parity_window_counter;
  import parity_window_counter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  parity_window_counter_if bus ();

  parity_window_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.win_len = 8'd0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.odd_cnt !== 8'd0 || bus.even_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.odd_cnt, bus.even_cnt); end
    checks++; if (bus.acc_parity !== 1'b0 || bus.last_parity !== 1'b0) begin errors++; $display("FAIL reset_par got %b%b exp 00", bus.acc_parity, bus.last_parity); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] samples [4];
    samples[0] = 4'b0001; samples[1] = 4'b0011; samples[2] = 4'b0111; samples[3] = 4'b1111;
    bus.start = 1'b1; bus.win_len = 8'd4;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.data_in = samples[i];
      tick();
      if (i == 2) begin
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b exp 0", bus.done); end
      end
    end
    idle_inputs();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", bus.busy); end
    checks++; if (bus.odd_cnt !== 8'd2 || bus.even_cnt !== 8'd2) begin errors++; $display("FAIL basic_cnt got %0d/%0d exp 2/2", bus.odd_cnt, bus.even_cnt); end
    checks++; if (bus.acc_parity !== 1'b0 || bus.last_parity !== 1'b0) begin errors++; $display("FAIL basic_par got %b%b exp 00", bus.acc_parity, bus.last_parity); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", bus.done); end
    checks++; if (bus.odd_cnt !== 8'd2 || bus.even_cnt !== 8'd2) begin errors++; $display("FAIL basic_hold got %0d/%0d exp 2/2", bus.odd_cnt, bus.even_cnt); end
  endtask

  task automatic test_stalls();
    bus.start = 1'b1; bus.win_len = 8'd3;
    tick();
    bus.start = 1'b0; bus.win_len = 8'd7;
    bus.in_valid = 1'b1; bus.data_in = 4'b1000;
    tick();
    bus.in_valid = 1'b0; bus.data_in = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.odd_cnt !== 8'd1 || bus.even_cnt !== 8'd0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL stall_gap got odd=%0d even=%0d done=%b busy=%b exp 1/0/0/1", bus.odd_cnt, bus.even_cnt, bus.done, bus.busy);
      end
    end
    bus.in_valid = 1'b1; bus.data_in = 4'b1010;
    tick();
    checks++; if (bus.done !== 1'b0 || bus.even_cnt !== 8'd1) begin errors++; $display("FAIL stall_second got done=%b even=%0d exp 0/1", bus.done, bus.even_cnt); end
    bus.data_in = 4'b1110;
    tick();
    idle_inputs();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", bus.done); end
    checks++; if (bus.odd_cnt !== 8'd2 || bus.even_cnt !== 8'd1) begin errors++; $display("FAIL stall_cnt got %0d/%0d exp 2/1", bus.odd_cnt, bus.even_cnt); end
    checks++; if (bus.acc_parity !== 1'b0 || bus.last_parity !== 1'b1) begin errors++; $display("FAIL stall_par got %b%b exp 01", bus.acc_parity, bus.last_parity); end
    tick();
  endtask

  task automatic test_start_in_count();
    bus.start = 1'b1; bus.win_len = 8'd2;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.data_in = 4'b0001;
    tick();
    bus.in_valid = 1'b0; bus.start = 1'b1; bus.win_len = 8'd9;
    tick();
    checks++; if (bus.odd_cnt !== 8'd1 || bus.busy !== 1'b1 || bus.acc_parity !== 1'b1) begin
      errors++; $display("FAIL restart_noclear got odd=%0d busy=%b acc=%b exp 1/1/1", bus.odd_cnt, bus.busy, bus.acc_parity);
    end
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.data_in = 4'b0001;
    tick();
    idle_inputs();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL restart_done got %b exp 1", bus.done); end
    checks++; if (bus.odd_cnt !== 8'd2 || bus.even_cnt !== 8'd0 || bus.acc_parity !== 1'b0) begin
      errors++; $display("FAIL restart_cnt got odd=%0d even=%0d acc=%b exp 2/0/0", bus.odd_cnt, bus.even_cnt, bus.acc_parity);
    end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL restart_single got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_empty_window();
    bus.start = 1'b1; bus.win_len = 8'd0;
    tick();
    idle_inputs();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL empty_done got done=%b busy=%b exp 1/0", bus.done, bus.busy); end
    checks++; if (bus.odd_cnt !== 8'd0 || bus.even_cnt !== 8'd0) begin errors++; $display("FAIL empty_cnt got %0d/%0d exp 0/0", bus.odd_cnt, bus.even_cnt); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL empty_after got done=%b busy=%b exp 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_reset_mid_window();
    bus.start = 1'b1; bus.win_len = 8'd10;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.data_in = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.odd_cnt !== 8'd5 || bus.acc_parity !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got odd=%0d acc=%b busy=%b exp 5/1/1", bus.odd_cnt, bus.acc_parity, bus.busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.odd_cnt !== 8'd0 || bus.busy !== 1'b0 || bus.acc_parity !== 1'b0 || bus.last_parity !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_async got odd=%0d busy=%b acc=%b last=%b done=%b exp all 0", bus.odd_cnt, bus.busy, bus.acc_parity, bus.last_parity, bus.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.odd_cnt !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got odd=%0d busy=%b done=%b exp 0/0/0", bus.odd_cnt, bus.busy, bus.done);
    end
    idle_inputs();
  endtask

  task automatic test_max_window();
    bus.start = 1'b1; bus.win_len = 8'd255;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.data_in = 4'b1000;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 253) begin
        checks++; if (bus.done !== 1'b0 || bus.odd_cnt !== 8'd254) begin errors++; $display("FAIL max_pre got done=%b odd=%0d exp 0/254", bus.done, bus.odd_cnt); end
      end
    end
    idle_inputs();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL max_done got %b exp 1", bus.done); end
    checks++; if (bus.odd_cnt !== 8'd255 || bus.even_cnt !== 8'd0 || bus.acc_parity !== 1'b1) begin
      errors++; $display("FAIL max_cnt got odd=%0d even=%0d acc=%b exp 255/0/1", bus.odd_cnt, bus.even_cnt, bus.acc_parity);
    end
    bus.in_valid = 1'b1; bus.data_in = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.odd_cnt !== 8'd255 || bus.even_cnt !== 8'd0 || bus.acc_parity !== 1'b1 || bus.last_parity !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL max_hold cycle %0d got odd=%0d even=%0d acc=%b last=%b done=%b exp 255/0/1/1/0", i, bus.odd_cnt, bus.even_cnt, bus.acc_parity, bus.last_parity, bus.done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stalls();
    test_start_in_count();
    test_empty_window();
    test_reset_mid_window();
    test_max_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
